// File: rtl/elev_pkg.sv
// Shared definitions for the elevator request scheduler.
//   - sched_state_e : scheduler FSM state encodings
//   - FloorWDef     : default floor index width
//   - NumFloorsDef  : default number of served floors
//   - DoorCyclesDef : default door-open dwell in clock cycles
package elev_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StSweepUp   = 2'd1,
    StSweepDown = 2'd2,
    StDoor      = 2'd3
  } sched_state_e;

  localparam int unsigned FloorWDef     = 4;
  localparam int unsigned NumFloorsDef  = 10;
  localparam int unsigned DoorCyclesDef = 10000000;

endpackage

// File: rtl/floor_select.sv
// Combinational nearest-call finder.
// Given the pending-call vector and the (already clamped) current floor, returns the lowest pending
// floor strictly above and the highest pending floor strictly below the car.
//   pending_i     : outstanding calls, one bit per floor
//   cur_floor_i   : car position, must be < NumFloors
//   above_floor_o : lowest pending floor > cur_floor_i (valid when above_valid_o)
//   below_floor_o : highest pending floor < cur_floor_i (valid when below_valid_o)
module floor_select
  import elev_pkg::*;
#(
  parameter int unsigned NumFloors = NumFloorsDef,
  parameter int unsigned FloorW    = FloorWDef
) (
  input  logic [NumFloors-1:0] pending_i,
  input  logic [FloorW-1:0]    cur_floor_i,
  output logic [FloorW-1:0]    above_floor_o,
  output logic                 above_valid_o,
  output logic [FloorW-1:0]    below_floor_o,
  output logic                 below_valid_o
);

  always_comb begin
    above_floor_o = '0;
    above_valid_o = 1'b0;
    below_floor_o = '0;
    below_valid_o = 1'b0;
    // Scan top-down so the last hit above the car is the lowest one.
    for (int i = int'(NumFloors) - 1; i >= 0; i--) begin
      if (pending_i[i] && (FloorW'(i) > cur_floor_i)) begin
        above_floor_o = FloorW'(i);
        above_valid_o = 1'b1;
      end
    end
    // Scan bottom-up so the last hit below the car is the highest one.
    for (int i = 0; i < int'(NumFloors); i++) begin
      if (pending_i[i] && (FloorW'(i) < cur_floor_i)) begin
        below_floor_o = FloorW'(i);
        below_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// LOOK-policy elevator request scheduler.
// Latches floor calls into a pending register, picks the next floor for the motion FSM, runs the
// door dwell timer on arrival and clears served calls.
//   clk, rst_n     : clock, asynchronous active-low reset
//   call_req       : per-floor call buttons (any high cycle registers a call)
//   current_floor  : car position from the motion FSM
//   car_idle       : motion FSM is stopped
//   target_floor   : requested floor for the motion FSM
//   target_valid   : a target is being served
//   dir_up         : current sweep direction (1 = up)
//   door_open      : door dwell active
//   pending        : registered outstanding calls
// Optional feature: define ELEV_SCHED_FIRE_RECALL_EN to add the fire_recall input, which clears and
// freezes all calls, sends the car to floor 0 and holds the door open there until released.
module elevator_request_scheduler
  import elev_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = NumFloorsDef,
  parameter int unsigned FLOOR_W     = FloorWDef,
  parameter int unsigned DOOR_CYCLES = DoorCyclesDef
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  car_idle,
`ifdef ELEV_SCHED_FIRE_RECALL_EN
  input  logic                  fire_recall,
`endif
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  dir_up,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned         CntW     = $clog2(DOOR_CYCLES);
  localparam logic [CntW-1:0]     CntLoad  = CntW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]  TopFloor = FLOOR_W'(NUM_FLOORS - 1);

  sched_state_e          state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic                  target_valid_q, target_valid_d;
  logic                  dir_up_q, dir_up_d;
  logic [CntW-1:0]       counter_q, counter_d;

  logic [FLOOR_W-1:0]    cur;
  logic [NUM_FLOORS-1:0] cur_oh;
  logic [FLOOR_W-1:0]    above_floor, below_floor;
  logic                  above_valid, below_valid;
  logic [FLOOR_W-1:0]    up_dist, dn_dist;
  logic                  at_target;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask;

  // Out-of-range positions are treated as the top floor.
  assign cur       = (current_floor > TopFloor) ? TopFloor : current_floor;
  assign cur_oh    = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << cur;
  assign up_dist   = above_floor - cur;
  assign dn_dist   = cur - below_floor;
  assign at_target = target_valid_q && (cur == target_q);

  floor_select #(
    .NumFloors(NUM_FLOORS),
    .FloorW   (FLOOR_W)
  ) u_floor_select (
    .pending_i    (pending_q),
    .cur_floor_i  (cur),
    .above_floor_o(above_floor),
    .above_valid_o(above_valid),
    .below_floor_o(below_floor),
    .below_valid_o(below_valid)
  );

`ifdef ELEV_SCHED_FIRE_RECALL_EN
  logic recall_q, recall_d;
`endif

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    target_valid_d = target_valid_q;
    dir_up_d       = dir_up_q;
    counter_d      = counter_q;
    set_mask       = call_req;
    clr_mask       = '0;

    case (state_q)
      StIdle: begin
        target_d       = cur;
        target_valid_d = 1'b0;
        if (|(pending_q & cur_oh) && car_idle) begin
          state_d   = StDoor;
          clr_mask  = cur_oh;
          counter_d = CntLoad;
        end else if (above_valid && (!below_valid || (up_dist <= dn_dist))) begin
          // Equal distance resolves upward.
          state_d        = StSweepUp;
          target_d       = above_floor;
          target_valid_d = 1'b1;
          dir_up_d       = 1'b1;
        end else if (below_valid) begin
          state_d        = StSweepDown;
          target_d       = below_floor;
          target_valid_d = 1'b1;
          dir_up_d       = 1'b0;
        end
      end

      StSweepUp, StSweepDown: begin
        if (at_target) begin
          // Hold the target until the car has actually stopped there.
          if (car_idle) begin
            state_d        = StDoor;
            clr_mask       = cur_oh;
            counter_d      = CntLoad;
            target_valid_d = 1'b0;
          end
        end else if ((state_q == StSweepUp) && above_valid) begin
          // Nearest-above naturally retargets onto calls landing before the old target.
          target_d       = above_floor;
          target_valid_d = 1'b1;
        end else if ((state_q == StSweepDown) && below_valid) begin
          target_d       = below_floor;
          target_valid_d = 1'b1;
        end else if (below_valid) begin
          state_d        = StSweepDown;
          target_d       = below_floor;
          target_valid_d = 1'b1;
          dir_up_d       = 1'b0;
        end else if (above_valid) begin
          state_d        = StSweepUp;
          target_d       = above_floor;
          target_valid_d = 1'b1;
          dir_up_d       = 1'b1;
        end else begin
          state_d        = StIdle;
          target_d       = cur;
          target_valid_d = 1'b0;
        end
      end

      StDoor: begin
        target_valid_d = 1'b0;
        // A press at the open floor only extends the dwell.
        set_mask       = call_req & ~cur_oh;
        if (|(call_req & cur_oh)) begin
          counter_d = CntLoad;
        end else if (counter_q != '0) begin
          counter_d = counter_q - 1'b1;
        end else if (dir_up_q && above_valid) begin
          state_d        = StSweepUp;
          target_d       = above_floor;
          target_valid_d = 1'b1;
        end else if (!dir_up_q && below_valid) begin
          state_d        = StSweepDown;
          target_d       = below_floor;
          target_valid_d = 1'b1;
        end else if (above_valid) begin
          state_d        = StSweepUp;
          target_d       = above_floor;
          target_valid_d = 1'b1;
          dir_up_d       = 1'b1;
        end else if (below_valid) begin
          state_d        = StSweepDown;
          target_d       = below_floor;
          target_valid_d = 1'b1;
          dir_up_d       = 1'b0;
        end else begin
          state_d  = StIdle;
          target_d = cur;
        end
      end

      default: state_d = StIdle;
    endcase

    // Clear beats set: a floor being served cannot re-register in the same cycle.
    pending_d = (pending_q | set_mask) & ~clr_mask;

`ifdef ELEV_SCHED_FIRE_RECALL_EN
    recall_d = fire_recall;
    if (fire_recall) begin
      pending_d = '0;
      target_d  = '0;
      counter_d = '0;
      if ((cur == '0 && car_idle) || (recall_q && state_q == StDoor)) begin
        state_d        = StDoor;
        target_valid_d = 1'b0;
      end else begin
        state_d        = StSweepDown;
        target_valid_d = 1'b1;
        dir_up_d       = 1'b0;
      end
    end else if (recall_q) begin
      // Release: restart from an empty, idle scheduler.
      state_d        = StIdle;
      pending_d      = '0;
      target_d       = cur;
      target_valid_d = 1'b0;
      counter_d      = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      pending_q      <= '0;
      target_q       <= '0;
      target_valid_q <= 1'b0;
      dir_up_q       <= 1'b1;
      counter_q      <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      dir_up_q       <= dir_up_d;
      counter_q      <= counter_d;
    end
  end

`ifdef ELEV_SCHED_FIRE_RECALL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recall_q <= 1'b0;
    end else begin
      recall_q <= recall_d;
    end
  end
`endif

  assign target_floor = target_q;
  assign target_valid = target_valid_q;
  assign dir_up       = dir_up_q;
  assign door_open    = (state_q == StDoor);
  assign pending      = pending_q;

endmodule

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Collects floor-call button presses, holds them in a pending-request register and selects the next floor for the elevator motion FSM to drive toward, using a LOOK (sweep-direction) policy. Sits between the ui_in call buttons and the motion FSM's requested_floor input. Observes the car's current_floor and idle status, runs a door-open dwell timer on arrival, and clears served requests.

## Interface
- NUM_FLOORS, 10, number of served floors (2..16); floors 0..NUM_FLOORS-1
- FLOOR_W, 4, floor index width
- DOOR_CYCLES, 10000000, door-open dwell in clk cycles (≥2)
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- call_req  in  NUM_FLOORS  level/pulse per floor; any cycle high registers a call
- current_floor  in  FLOOR_W  car position from motion FSM
- car_idle  in  1  motion FSM in IDLE (not moving)
- target_floor  out  FLOOR_W  floor to drive to motion FSM requested_floor
- target_valid  out  1  a target is being served
- dir_up  out  1  current sweep direction (1 = up)
- door_open  out  1  door dwell active
- pending  out  NUM_FLOORS  registered outstanding calls

## Operation
- States: IDLE, SWEEP_UP, SWEEP_DOWN, DOOR.
- pending[i] set on any cycle call_req[i]=1; cleared only when floor i is served (entry to DOOR at floor i). Set wins over nothing else; see DOOR rule.
- IDLE: no pending → stay, target_floor holds current_floor, target_valid=0. Pending at current_floor with car_idle → DOOR. Else pick nearest pending floor; distance tie → upward; go SWEEP_UP/SWEEP_DOWN, dir_up accordingly.
- SWEEP_UP: target = lowest pending floor > current_floor. None above: pending below → SWEEP_DOWN, else → IDLE.
- SWEEP_DOWN: mirror (highest pending floor < current_floor; none → SWEEP_UP if any above, else IDLE).
- Target retargets mid-sweep when a new call lands between car and current target in sweep direction.
- Arrival: car_idle=1 and current_floor==target_floor with target_valid → DOOR, clear pending[target], load dwell counter.
- DOOR: door_open=1, target_valid=0, counter counts DOOR_CYCLES. call_req at current_floor during DOOR restarts counter and does not set pending. Counter expiry → re-evaluate in current dir_up (SWEEP same dir if work remains that way, else reverse, else IDLE).
- call_req bits ≥ NUM_FLOORS ignored; current_floor ≥ NUM_FLOORS treated as NUM_FLOORS-1 for selection.

## Timing
- Reset values: state IDLE, pending=0, target_floor=0, target_valid=0, dir_up=1, door_open=0, counter=0.
- call_req sampled at clk edge; pending visible next cycle; target_floor/target_valid registered, update one cycle after pending (two cycles after call).
- Arrival → door_open=1 next cycle; door_open high exactly DOOR_CYCLES cycles absent re-press.
- Simultaneous call and clear on same floor same cycle: clear wins (floor is being served).
- rst_n low mid-sweep or mid-door: all outputs to reset values immediately, pending lost.

## Configuration
- ELEV_SCHED_FIRE_RECALL_EN defined: adds input fire_recall (1 bit). While high: pending cleared and frozen, calls ignored, target_floor=0, target_valid=1 until arrival at 0, then door_open=1 held while fire_recall stays high; on release → IDLE with empty pending.
- Undefined: no port, no logic; behaviour as above.

## Structure
- Shared package elev_pkg: state enum encodings, FLOOR_W, default NUM_FLOORS, default DOOR_CYCLES.
- One sub-module floor_select: combinational; given pending and current_floor, outputs nearest_above, nearest_below and their valid flags. Scheduler FSM, pending register and dwell counter stay in top.

## Test plan
- Reset, car_idle=1, floor 0, pulse call_req[5] → pending=0x020 next cycle, target_floor=5, target_valid=1, dir_up=1 one cycle later.
- Car at 3 sweeping up to 7, press 5 → target retargets to 5; arrival at 5 → door_open DOOR_CYCLES cycles (set 4 in bench), then target 7.
- Car idle at 4, pending 2 and 6 → target 6 (tie upward); after serving 6 → SWEEP_DOWN, target 2.
- During DOOR at floor 3, pulse call_req[3] at dwell cycle 2 → counter restarts, pending[3] stays 0, door_open lasts 2+DOOR_CYCLES.
- Assert rst_n low mid-sweep with pending 0x0FF → all outputs reset values, pending=0 while low and after release.
- With ELEV_SCHED_FIRE_RECALL_EN, pending 0x210, car at 6, raise fire_recall → pending=0, target_floor=0; calls ignored; door_open held at floor 0 until release.
